alu_control_md: RTL

- Next-generation ALU control for the RV32 core, parametrised in datapath width.
- Decodes ALUOp/funct3/funct7 into the 4-bit ALU select for single-cycle ops.
- Adds RV32M support: an iterative multiply/divide engine with a stall handshake to the pipeline.
- Sits between the control unit and the EX stage. Result mux selects md_result when md_done=1.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/md_iter_core.sv | 91 +++++++++
 rtl/alu_control_md.sv | 53 +++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, ALUOp classes, M-extension op and FSM state types
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [2:0] OP_R  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_LS = 3'b010;
  localparam logic [2:0] OP_I  = 3'b011;
  localparam logic [2:0] OP_U  = 3'b100;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} md_op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: iterative shift-add multiplier / restoring divider with sign fixup and special cases
module md_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  md_state_t        state_q;
  md_op_t           op_q, op_in;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, d_q, res_q;
  logic             negq_q, negr_q;
  logic             sa, sb, is_div, div_zero, ovf;
  logic [WIDTH-1:0] ma, mb, sp_res, hi_d, lo_d, diff, quo, rem, fin;
  logic [WIDTH:0]   sum, sh;
  logic             ge, div_q;
  logic [2*WIDTH-1:0] prod;
  assign op_in    = md_op_t'(funct3_i);
  assign is_div   = funct3_i[2];
  assign sa       = a_i[WIDTH-1] & (op_in inside {MULH, MULHSU, DIV, REM});
  assign sb       = b_i[WIDTH-1] & (op_in inside {MULH, DIV, REM});
  assign ma       = sa ? -a_i : a_i;
  assign mb       = sb ? -b_i : b_i;
  assign div_zero = is_div & (b_i == '0);
  assign ovf      = is_div & ~funct3_i[0] & (a_i == MIN_NEG) & (b_i == '1);
  assign sp_res   = div_zero ? (funct3_i[1] ? a_i : '1) : (funct3_i[1] ? '0 : a_i);
  assign div_q    = op_q inside {DIV, DIVU, REM, REMU};
  // hi holds accumulator/remainder, lo holds multiplier/quotient; d is the fixed operand
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    sh   = {hi_q, lo_q[WIDTH-1]};
    ge   = sh >= {1'b0, d_q};
    diff = sh[WIDTH-1:0] - d_q;
    hi_d = div_q ? (ge ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
    lo_d = div_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    prod = negq_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    quo  = negq_q ? -lo_d : lo_d;
    rem  = negr_q ? -hi_d : hi_d;
    fin  = (op_q == MUL) ? prod[WIDTH-1:0] :
           (op_q inside {MULH, MULHSU, MULHU}) ? prod[2*WIDTH-1:WIDTH] :
           (op_q inside {DIV, DIVU}) ? quo : rem;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MUL;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          op_q    <= op_in;
          negq_q  <= sa ^ sb;
          negr_q  <= sa;
          hi_q    <= '0;
          lo_q    <= is_div ? ma : mb;
          d_q     <= is_div ? mb : ma;
          cnt_q   <= CNT_W'(WIDTH);
          res_q   <= (div_zero | ovf) ? sp_res : res_q;
          state_q <= (div_zero | ovf) ? DONE : BUSY;
        end
        BUSY: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          cnt_q   <= cnt_q - 1'b1;
          res_q   <= (cnt_q == CNT_W'(1)) ? fin : res_q;
          state_q <= (cnt_q == CNT_W'(1)) ? DONE : BUSY;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done_o   = (state_q == DONE);
  assign result_o = res_q;
endmodule

// File: rtl/alu_control_md.sv
// alu_control_md: RV32 ALU select decode plus RV32M iterative mul/div with pipeline stall
module alu_control_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       ALU_control,
  output logic             is_md,
  output logic             md_stall,
  output logic             md_done,
  output logic [WIDTH-1:0] md_result
);
  logic [3:0] rt_code, b_code;
  always_comb begin
    rt_code = ALU_ADD;
    case (funct3)
      3'b000: rt_code = (ALUOp == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: rt_code = ALU_SLL;
      3'b010: rt_code = ALU_SLT;
      3'b011: rt_code = ALU_SLTU;
      3'b100: rt_code = ALU_XOR;
      3'b101: rt_code = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: rt_code = ALU_OR;
      3'b111: rt_code = ALU_AND;
    endcase
  end
  assign b_code      = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
  assign is_md       = (ALUOp == OP_R) & funct7_0;
  assign ALU_control = (is_md || ALUOp inside {OP_LS, OP_U}) ? ALU_ADD :
                       (ALUOp inside {OP_R, OP_I}) ? rt_code :
                       (ALUOp == OP_B) ? b_code : ALU_ADD;
  assign md_stall    = valid_in & is_md & ~md_done;
  md_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk      (CLK),
    .rst      (RST),
    .start_i  (valid_in & is_md),
    .funct3_i (funct3),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (md_done),
    .result_o (md_result)
  );
endmodule
